wptr_ctrl: RTL and testbench

WPTR_CTRL -- requirements
Module: wptr_ctrl

---
 rtl/wptr_ctrl_pkg.sv | 50 +++++
 rtl/ptr_sync.sv | 38 +++
 rtl/wptr_ctrl.sv | 145 ++++++++++++++
 tb/tb_wptr_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wptr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wptr_ctrl_pkg
// Shared definitions for the async-FIFO write-pointer controller.
//   - DefAddrW / DefAfullTh : default address width and almost-full threshold
//   - ptr_t                 : wide carrier type used by the Gray helpers
//   - bin2gray / gray2bin   : width-parametrised Gray conversions, computed
//                             arithmetically (no lookup tables)
// No ports (package).
// -----------------------------------------------------------------------------
package wptr_ctrl_pkg;

  localparam int unsigned DefAddrW   = 3;
  localparam int unsigned DefAfullTh = 6;

  // Widest pointer the helpers accept; callers zero-extend into ptr_t and
  // truncate the result back to their own width.
  localparam int unsigned PtrMaxW = 32;

  typedef logic [PtrMaxW-1:0] ptr_t;

  // All-ones mask covering the low 'width' bits.
  function automatic ptr_t width_mask(input int unsigned width);
    ptr_t m;
    if (width >= PtrMaxW) begin
      m = '1;
    end else begin
      m = (ptr_t'(1) << width) - ptr_t'(1);
    end
    return m;
  endfunction

  // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
  function automatic ptr_t bin2gray(input ptr_t b, input int unsigned width);
    ptr_t bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above
  // it. Bits above 'width' are masked to zero so they do not contribute.
  function automatic ptr_t gray2bin(input ptr_t g, input int unsigned width);
    ptr_t b;
    b = g & width_mask(width);
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// Two-flop synchroniser bringing a Gray pointer from the read domain into
// the write-clock domain. Only one bit of a Gray pointer changes per step, so
// a metastable capture resolves to either the old or the new pointer value.
// Parameters:
//   WIDTH : pointer width
// Ports:
//   wclk  : destination (write-domain) clock
//   wrst  : asynchronous active-high reset, clears both flops
//   d     : pointer from the source domain (asynchronous to wclk)
//   q     : synchronised pointer, delayed by two wclk edges
// -----------------------------------------------------------------------------
module ptr_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/wptr_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_ctrl
// Write-side pointer and flag logic of an asynchronous FIFO.
// Parameters:
//   ADDR_W   : memory address width, FIFO depth is 2**ADDR_W (ADDR_W >= 2)
//   AFULL_TH : almost-full threshold, 1 .. 2**ADDR_W
// Ports:
//   wclk         : write-domain clock
//   wrst         : asynchronous active-high reset
//   winc         : write request
//   g_rptr       : Gray read pointer, raw from the read domain
//   wovf_clr     : clears the sticky overflow flag
//   wen          : memory write strobe (winc & ~wfull, combinational)
//   waddr        : memory write address
//   g_wptr       : registered Gray write pointer, to the read domain
//   wfull        : registered full flag
//   wlevel       : registered fill level, 0 .. 2**ADDR_W
//   wovf         : sticky overflow flag (write attempted while full)
//   walmost_full : registered level >= AFULL_TH; present only when the
//                  WPTR_CTRL_AFULL_EN macro is defined
// -----------------------------------------------------------------------------
module wptr_ctrl
  import wptr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned AFULL_TH = DefAfullTh
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              winc,
  input  logic [ADDR_W:0]   g_rptr,
  input  logic              wovf_clr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   g_wptr,
  output logic              wfull,
  output logic [ADDR_W:0]   wlevel,
  output logic              wovf
`ifdef WPTR_CTRL_AFULL_EN
  ,
  output logic              walmost_full
`endif
);

  localparam int unsigned PtrW = ADDR_W + 1;

  // Reject configurations the pointer arithmetic cannot represent.
  if (ADDR_W < 2 || ADDR_W > PtrMaxW - 1) begin : g_bad_addr_w
    $error("wptr_ctrl: ADDR_W out of range");
  end
  if (AFULL_TH < 1 || AFULL_TH > (1 << ADDR_W)) begin : g_bad_afull_th
    $error("wptr_ctrl: AFULL_TH out of range");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] r_wbin;
  logic [PtrW-1:0] r_gwptr;
  logic [PtrW-1:0] r_wlevel;
  logic            r_wfull;
  logic            r_wovf;

  // ---------------------------------------------------------------------------
  // Next-state terms
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] w_rq2;
  logic            w_wr_ok;
  logic [PtrW-1:0] w_wbin_next;
  logic [PtrW-1:0] w_gwptr_next;
  logic [PtrW-1:0] w_rbin_sync;
  logic [PtrW-1:0] w_level_next;
  logic [PtrW-1:0] w_full_ref;
  logic            w_full_next;
  logic            w_ovf_set;

  ptr_sync #(
    .WIDTH (PtrW)
  ) u_rptr_sync (
    .wclk (wclk),
    .wrst (wrst),
    .d    (g_rptr),
    .q    (w_rq2)
  );

  always_comb begin
    w_wr_ok      = winc & ~r_wfull;
    w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_wr_ok};
    w_gwptr_next = PtrW'(bin2gray(PtrMaxW'(w_wbin_next), PtrW));
    w_rbin_sync  = PtrW'(gray2bin(PtrMaxW'(w_rq2), PtrW));
    // Wraps modulo 2**PtrW, which is exactly the pointer distance.
    w_level_next = w_wbin_next - w_rbin_sync;
    // Full when the write pointer is one lap ahead of the read pointer: in
    // Gray code that is the read pointer with its top two bits inverted.
    w_full_ref   = {~w_rq2[ADDR_W -: 2], w_rq2[ADDR_W-2:0]};
    w_full_next  = (w_gwptr_next == w_full_ref);
    w_ovf_set    = winc & r_wfull;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin   <= '0;
      r_gwptr  <= '0;
      r_wlevel <= '0;
      r_wfull  <= 1'b0;
      r_wovf   <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_gwptr  <= w_gwptr_next;
      r_wlevel <= w_level_next;
      r_wfull  <= w_full_next;
      // A new overflow takes priority over a clear on the same edge.
      if (w_ovf_set) begin
        r_wovf <= 1'b1;
      end else if (wovf_clr) begin
        r_wovf <= 1'b0;
      end
    end
  end

`ifdef WPTR_CTRL_AFULL_EN
  logic r_walmost_full;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_walmost_full <= 1'b0;
    end else begin
      r_walmost_full <= (w_level_next >= PtrW'(AFULL_TH));
    end
  end

  assign walmost_full = r_walmost_full;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wen    = w_wr_ok;
  assign waddr  = r_wbin[ADDR_W-1:0];
  assign g_wptr = r_gwptr;
  assign wfull  = r_wfull;
  assign wlevel = r_wlevel;
  assign wovf   = r_wovf;

endmodule

// File: tb/tb_wptr_ctrl.sv
module tb_wptr_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned ATH   = 6;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [3:0] g_rptr;
  logic       wovf_clr;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] g_wptr;
  logic       wfull;
  logic [3:0] wlevel;
  logic       wovf;
`ifdef WPTR_CTRL_AFULL_EN
  logic       walmost_full;
`endif

  wptr_ctrl #(
    .ADDR_W   (AW),
    .AFULL_TH (ATH)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .winc     (winc),
    .g_rptr   (g_rptr),
    .wovf_clr (wovf_clr),
    .wen      (wen),
    .waddr    (waddr),
    .g_wptr   (g_wptr),
    .wfull    (wfull),
    .wlevel   (wlevel),
    .wovf     (wovf)
`ifdef WPTR_CTRL_AFULL_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks;
  int n_fail;

  // Reference model: unbounded write/read counts, with the read count seen
  // by the write side lagging by the two-stage crossing.
  int m_wcnt;
  int m_rd;
  int m_rd_d1;
  int m_rd_d2;
  int m_level;
  bit m_full;
  bit m_ovf;
  bit m_afull;
  bit cur_winc;
  bit cur_clr;

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    m_wcnt  = 0;
    m_rd    = 0;
    m_rd_d1 = 0;
    m_rd_d2 = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_afull = 1'b0;
  endtask

  // Apply inputs just after a falling edge; comb outputs settle by #1.
  task automatic drive(input bit w, input bit clr);
    cur_winc = w;
    cur_clr  = clr;
    winc     = w;
    wovf_clr = clr;
    g_rptr   = gray4(m_rd);
    #1;
  endtask

  // Advance one write clock, update the model, return at the falling edge.
  task automatic clock_edge();
    bit accept;
    @(posedge wclk);
    accept = cur_winc && !m_full;
    if (cur_winc && m_full) m_ovf = 1'b1;
    else if (cur_clr) m_ovf = 1'b0;
    if (accept) m_wcnt++;
    m_level = m_wcnt - m_rd_d2;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= ATH);
    m_rd_d2 = m_rd_d1;
    m_rd_d1 = m_rd;
    @(negedge wclk);
  endtask

  task automatic do_reset();
    winc     = 1'b0;
    wovf_clr = 1'b0;
    cur_winc = 1'b0;
    cur_clr  = 1'b0;
    model_clear();
    g_rptr   = 4'b0000;
    wrst     = 1'b1;
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({wen, waddr, g_wptr, wfull, wlevel, wovf} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {wen, waddr, g_wptr, wfull, wlevel, wovf});
    end
`ifdef WPTR_CTRL_AFULL_EN
    n_checks++;
    if (walmost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_afull: got %b required 0", walmost_full);
    end
`endif
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (wen !== 1'b1 || waddr !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_write[%0d]: got wen=%b waddr=%0d required wen=1 waddr=%0d",
                 i, wen, waddr, i);
      end
      clock_edge();
      if (i < 7) begin
        n_checks++;
        if (wfull !== 1'b0 || wlevel !== 4'(i + 1)) begin
          n_fail++;
          $display("FAIL fill_level[%0d]: got full=%b level=%0d required full=0 level=%0d",
                   i, wfull, wlevel, i + 1);
        end
      end
    end
    n_checks++;
    if (wfull !== 1'b1 || wlevel !== 4'd8 || g_wptr !== 4'b1100) begin
      n_fail++;
      $display("FAIL fill_final: got full=%b level=%0d gw=%b required full=1 level=8 gw=1100",
               wfull, wlevel, g_wptr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0);
      n_checks++;
      if (wen !== 1'b0 || waddr !== 3'd0) begin
        n_fail++;
        $display("FAIL ovf_block[%0d]: got wen=%b waddr=%0d required wen=0 waddr=0",
                 i, wen, waddr);
      end
      clock_edge();
      n_checks++;
      if (wovf !== 1'b1 || g_wptr !== 4'b1100) begin
        n_fail++;
        $display("FAIL ovf_set[%0d]: got ovf=%b gw=%b required ovf=1 gw=1100", i, wovf, g_wptr);
      end
    end
    drive(1'b0, 1'b1);
    clock_edge();
    n_checks++;
    if (wovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b required 0", wovf);
    end
    // Set and clear on the same edge: the set wins.
    drive(1'b1, 1'b1);
    clock_edge();
    n_checks++;
    if (wovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b required 1", wovf);
    end
    drive(1'b0, 1'b1);
    clock_edge();
    n_checks++;
    if (wovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear2: got %b required 0", wovf);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_drain();
    m_rd = 1;
    for (int e = 1; e <= 3; e++) begin
      drive(1'b0, 1'b0);
      clock_edge();
      n_checks++;
      if (e < 3 && (wfull !== 1'b1 || wlevel !== 4'd8)) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: got full=%b level=%0d required full=1 level=8",
                 e, wfull, wlevel);
      end else if (e == 3 && (wfull !== 1'b0 || wlevel !== 4'd7)) begin
        n_fail++;
        $display("FAIL drain_edge3: got full=%b level=%0d required full=0 level=7",
                 wfull, wlevel);
      end
    end
  endtask

  task automatic test_wrap();
    int full_seen;
    full_seen = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      clock_edge();
      if (wfull !== 1'b0) full_seen++;
      m_rd++;
      drive(1'b0, 1'b0);
      clock_edge();
      if (wfull !== 1'b0) full_seen++;
    end
    n_checks++;
    if (full_seen != 0) begin
      n_fail++;
      $display("FAIL wrap_never_full: got %0d full cycles required 0", full_seen);
    end
    n_checks++;
    if (g_wptr !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_gwptr: got %b required 0000", g_wptr);
    end
  endtask

`ifdef WPTR_CTRL_AFULL_EN
  task automatic test_afull();
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b0);
      clock_edge();
      if (i == 5) begin
        n_checks++;
        if (walmost_full !== 1'b0) begin
          n_fail++;
          $display("FAIL afull_after5: got %b required 0", walmost_full);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (walmost_full !== 1'b1) begin
          n_fail++;
          $display("FAIL afull_after6: got %b required 1", walmost_full);
        end
      end
    end
    drive(1'b0, 1'b0);
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      clock_edge();
    end
    drive(1'b0, 1'b0);
    #1;
    wrst = 1'b1;
    #1;
    n_checks++;
    if ({wen, waddr, g_wptr, wfull, wlevel, wovf} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b required all zero",
               {wen, waddr, g_wptr, wfull, wlevel, wovf});
    end
    model_clear();
    g_rptr = 4'b0000;
    #1;
    wrst = 1'b0;
    clock_edge();
    drive(1'b1, 1'b0);
    n_checks++;
    if (wen !== 1'b1 || waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_write: got wen=%b waddr=%0d required wen=1 waddr=0", wen, waddr);
    end
    clock_edge();
    n_checks++;
    if (wlevel !== 4'd1 || g_wptr !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_state: got level=%0d gw=%b required level=1 gw=0001",
               wlevel, g_wptr);
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit w;
    bit c;
    for (int i = 0; i < 500; i++) begin
      w = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 9) == 0);
      if (m_rd < m_wcnt && $urandom_range(0, 1) == 1) m_rd++;
      drive(w, c);
      n_checks++;
      if (wen !== (w && !m_full) || waddr !== 3'(m_wcnt)) begin
        n_fail++;
        $display("FAIL rand_comb[%0d]: got wen=%b waddr=%0d required wen=%b waddr=%0d",
                 i, wen, waddr, w && !m_full, 3'(m_wcnt));
      end
      clock_edge();
      n_checks++;
      if (g_wptr !== gray4(m_wcnt) || wfull !== m_full || wlevel !== 4'(m_level)
          || wovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_reg[%0d]: got gw=%b full=%b lvl=%0d ovf=%b required gw=%b full=%b lvl=%0d ovf=%b",
                 i, g_wptr, wfull, wlevel, wovf, gray4(m_wcnt), m_full, m_level, m_ovf);
      end
`ifdef WPTR_CTRL_AFULL_EN
      n_checks++;
      if (walmost_full !== m_afull) begin
        n_fail++;
        $display("FAIL rand_afull[%0d]: got %b required %b", i, walmost_full, m_afull);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    cur_winc = 1'b0;
    cur_clr  = 1'b0;
    wrst     = 1'b1;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    g_rptr   = 4'b0000;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    do_reset();
    test_wrap();
`ifdef WPTR_CTRL_AFULL_EN
    do_reset();
    test_afull();
`endif
    do_reset();
    test_async_reset();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
